// File: rtl/game_controller.sv
// game_controller: IDLE/PLAY/DEAD sequencer with frame divider, start/flap edge detect, score and optional best score (macro HIGH_SCORE_EN).
// Latency: every output is registered and responds one cycle after the edge that samples its cause.
// Backpressure: none; inputs are levels/pulses consumed every cycle and outputs are strobes or levels.
module game_controller #(
    parameter logic [19:0] FRAME_DIV   = 20'd833333,
    parameter logic [7:0]  DEAD_FRAMES = 8'd120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       flap,
    input  logic       collision,
    input  logic       score_pulse,
    output logic [1:0] state,
    output logic       play_en,
    output logic       clear,
    output logic       frame_tick,
    output logic       flap_o,
    output logic       loser,
    output logic [7:0] score,
    output logic [7:0] best
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        start_prev;
    logic        flap_prev;
    logic        start_edge;
    logic        flap_edge;

    logic [19:0] div_q;
    logic [19:0] div_d;
    logic        div_wrap;
    logic        tick_d;

    logic [7:0]  dead_q;
    logic [7:0]  dead_d;
    logic        dead_done;

    logic [7:0]  score_q;
    logic [7:0]  score_d;

    logic        clear_d;
    logic        flap_d;

    // A held button produces exactly one edge because the previous level is registered.
    assign start_edge = start & ~start_prev;
    assign flap_edge  = flap  & ~flap_prev;

    // Divider terminal count and last dead-hold frame.
    assign div_wrap  = (div_q  == FRAME_DIV   - 20'd1);
    assign dead_done = (dead_q == DEAD_FRAMES - 8'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start edge begins a game, collision ends it, DEAD times out on frames.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (collision) begin
                    state_d = ST_DEAD;
                end
            end
            ST_DEAD: begin
                // Start edges are deliberately ignored here; only the frame timeout leaves DEAD.
                if (frame_tick && dead_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame divider: free-runs in PLAY/DEAD, pinned to zero in IDLE and on the way in/out of it.
    always_comb begin
        div_d  = '0;
        tick_d = 1'b0;
        if (state_q != ST_IDLE && state_d != ST_IDLE) begin
            div_d  = div_wrap ? 20'd0 : div_q + 20'd1;
            tick_d = div_wrap;
        end
    end

    // Dead-hold counter: zeroed on DEAD entry, advanced by each frame strobe seen in DEAD.
    always_comb begin
        dead_d = dead_q;
        case (state_q)
            ST_PLAY: begin
                if (collision) begin
                    dead_d = '0;
                end
            end
            ST_DEAD: begin
                if (frame_tick) begin
                    dead_d = dead_done ? 8'd0 : dead_q + 8'd1;
                end
            end
            default: begin
                dead_d = '0;
            end
        endcase
    end

    // Score, clear and flap command: collision in PLAY masks both score and flap.
    always_comb begin
        score_d = score_q;
        clear_d = 1'b0;
        flap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    clear_d = 1'b1;
                    score_d = '0;
                end
            end
            ST_PLAY: begin
                if (!collision) begin
                    if (score_pulse && score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    flap_d = flap_edge;
                end
            end
            default: begin
                score_d = score_q;
            end
        endcase
    end

    // Datapath and output registers; reset aborts without a clear pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev <= 1'b0;
            flap_prev  <= 1'b0;
            div_q      <= '0;
            dead_q     <= '0;
            score_q    <= '0;
            clear      <= 1'b0;
            frame_tick <= 1'b0;
            flap_o     <= 1'b0;
            play_en    <= 1'b0;
            loser      <= 1'b0;
        end else begin
            start_prev <= start;
            flap_prev  <= flap;
            div_q      <= div_d;
            dead_q     <= dead_d;
            score_q    <= score_d;
            clear      <= clear_d;
            frame_tick <= tick_d;
            flap_o     <= flap_d;
            play_en    <= (state_d == ST_PLAY);
            loser      <= (state_d == ST_DEAD);
        end
    end

    assign state = state_q;
    assign score = score_q;

`ifdef HIGH_SCORE_EN
    logic [7:0] best_q;

    // Running maximum captured on DEAD entry, using the post-update score of that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_q <= '0;
        end else if (state_q == ST_PLAY && state_d == ST_DEAD && score_d > best_q) begin
            best_q <= score_d;
        end
    end

    assign best = best_q;
`else
    assign best = 8'd0;
`endif

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

    localparam logic [19:0] FD = 20'd4;
    localparam logic [7:0]  DF = 8'd3;
`ifdef HIGH_SCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, flap, collision, score_pulse;
    logic [1:0] state;
    logic       play_en, clear, frame_tick, flap_o, loser;
    logic [7:0] score, best;

    int checks = 0;
    int errors = 0;

    game_controller #(.FRAME_DIV(FD), .DEAD_FRAMES(DF)) dut (
        .clk(clk), .rst(rst), .start(start), .flap(flap), .collision(collision),
        .score_pulse(score_pulse), .state(state), .play_en(play_en), .clear(clear),
        .frame_tick(frame_tick), .flap_o(flap_o), .loser(loser), .score(score), .best(best)
    );

    always #5 clk = ~clk;

    // Reference model: game rules in plain integers.
    int m_state, m_score, m_best, m_since, m_dead;
    bit m_ps, m_pf, m_clear, m_tick, m_flap;

    task automatic model_step(input bit r, input bit s, input bit f, input bit c, input bit p);
        bit se, fe;
        if (r) begin
            m_state = 0; m_score = 0; m_best = 0; m_since = 0; m_dead = 0;
            m_ps = 0; m_pf = 0; m_clear = 0; m_tick = 0; m_flap = 0;
        end else begin
            se = s && !m_ps;
            fe = f && !m_pf;
            m_ps = s;
            m_pf = f;
            m_clear = 0;
            m_flap = 0;
            case (m_state)
                0: begin
                    m_tick = 0;
                    if (se) begin
                        m_state = 1; m_clear = 1; m_score = 0; m_since = 0;
                    end
                end
                1: begin
                    m_since++;
                    m_tick = (m_since % int'(FD) == 0);
                    if (c) begin
                        m_state = 2;
                        m_dead = 0;
                        if (HS && m_score > m_best) m_best = m_score;
                    end else begin
                        if (p && m_score < 255) m_score++;
                        m_flap = fe;
                    end
                end
                default: begin
                    if (m_tick) m_dead++;
                    if (m_dead == int'(DF)) begin
                        m_state = 0; m_tick = 0; m_since = 0; m_dead = 0;
                    end else begin
                        m_since++;
                        m_tick = (m_since % int'(FD) == 0);
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive, let the DUT sample, advance the model, settle off the edge.
    task automatic cyc(input bit r, input bit s, input bit f, input bit c, input bit p);
        rst = r; start = s; flap = f; collision = c; score_pulse = p;
        @(posedge clk);
        model_step(r, s, f, c, p);
        #1;
    endtask

    task automatic check_model(input int n);
        chk($sformatf("rnd%0d_state", n), state, m_state);
        chk($sformatf("rnd%0d_play_en", n), play_en, (m_state == 1) ? 1 : 0);
        chk($sformatf("rnd%0d_loser", n), loser, (m_state == 2) ? 1 : 0);
        chk($sformatf("rnd%0d_clear", n), clear, m_clear);
        chk($sformatf("rnd%0d_tick", n), frame_tick, m_tick);
        chk($sformatf("rnd%0d_flap", n), flap_o, m_flap);
        chk($sformatf("rnd%0d_score", n), score, m_score);
        chk($sformatf("rnd%0d_best", n), best, m_best);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (state != 2'd0 && k < 60) begin
            cyc(0, 0, 0, 0, 0);
            k++;
        end
        chk(name, state, 0);
    endtask

    task automatic play_game(input int n, input int exp_best, input string name);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (n) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        chk({name, "_state"}, state, 2);
        chk({name, "_score"}, score, n);
        chk({name, "_best"}, best, exp_best);
        wait_idle({name, "_idle"});
    endtask

    typedef struct {
        bit r, s, f, c, p;
        int st, clr, tk, fl, sc, bst;
    } vec_t;

    vec_t tbl [0:22];

    initial begin
        int clears, ticks, flaps, first_tick, last_tick, bad_spacing;
        bit s_cur, f_cur;

        //            r s f c p  st clr tk fl sc bst
        tbl[0]  = '{1,0,0,0,0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1,0,0,0,0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0,1,0,0,0, 1, 1, 0, 0, 0, 0};
        tbl[3]  = '{0,1,0,0,0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{0,1,1,0,0, 1, 0, 0, 1, 0, 0};
        tbl[5]  = '{0,1,1,0,0, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{0,0,0,0,1, 1, 0, 1, 0, 1, 0};
        tbl[7]  = '{0,0,0,0,1, 1, 0, 0, 0, 2, 0};
        tbl[8]  = '{0,0,1,1,1, 2, 0, 0, 0, 2, 2};
        tbl[9]  = '{0,0,0,0,0, 2, 0, 0, 0, 2, 2};
        tbl[10] = '{0,0,0,0,0, 2, 0, 1, 0, 2, 2};
        tbl[11] = '{0,0,0,0,0, 2, 0, 0, 0, 2, 2};
        tbl[12] = '{0,1,0,0,0, 2, 0, 0, 0, 2, 2};
        tbl[13] = '{0,0,0,0,0, 2, 0, 0, 0, 2, 2};
        tbl[14] = '{0,0,0,0,0, 2, 0, 1, 0, 2, 2};
        tbl[15] = '{0,0,1,0,1, 2, 0, 0, 0, 2, 2};
        tbl[16] = '{0,0,0,0,0, 2, 0, 0, 0, 2, 2};
        tbl[17] = '{0,0,0,0,0, 2, 0, 0, 0, 2, 2};
        tbl[18] = '{0,0,0,0,0, 2, 0, 1, 0, 2, 2};
        tbl[19] = '{0,0,0,0,0, 0, 0, 0, 0, 2, 2};
        tbl[20] = '{0,0,1,0,0, 0, 0, 0, 0, 2, 2};
        tbl[21] = '{0,1,0,0,0, 1, 1, 0, 0, 0, 2};
        tbl[22] = '{1,1,0,0,0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1; start = 1'b0; flap = 1'b0; collision = 1'b0; score_pulse = 1'b0;

        // Vector table: reset, game start, flap, score vs collision, DEAD timeout, mid-game reset.
        for (int i = 0; i < 23; i++) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].c, tbl[i].p);
            chk($sformatf("t%0d_state", i), state, tbl[i].st);
            chk($sformatf("t%0d_play_en", i), play_en, (tbl[i].st == 1) ? 1 : 0);
            chk($sformatf("t%0d_loser", i), loser, (tbl[i].st == 2) ? 1 : 0);
            chk($sformatf("t%0d_clear", i), clear, tbl[i].clr);
            chk($sformatf("t%0d_tick", i), frame_tick, tbl[i].tk);
            chk($sformatf("t%0d_flap", i), flap_o, tbl[i].fl);
            chk($sformatf("t%0d_score", i), score, tbl[i].sc);
            chk($sformatf("t%0d_best", i), best, HS ? tbl[i].bst : 0);
        end

        // Start held 10 cycles, flap held from cycle 2: one clear, one flap, tick every 4.
        repeat (5) cyc(1, 0, 0, 0, 0);
        clears = 0; ticks = 0; flaps = 0; first_tick = -1; last_tick = -1; bad_spacing = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, (i < 10), (i >= 2), 0, 0);
            if (clear) clears++;
            if (flap_o) flaps++;
            if (frame_tick) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
                if (last_tick >= 0 && i - last_tick != 4) bad_spacing++;
                last_tick = i;
            end
        end
        chk("hold_clears", clears, 1);
        chk("hold_state", state, 1);
        chk("hold_play_en", play_en, 1);
        chk("hold_ticks", ticks, 4);
        chk("hold_first_tick", first_tick, 4);
        chk("hold_tick_spacing", bad_spacing, 0);
        chk("hold_flaps", flaps, 1);
        cyc(0, 0, 0, 1, 0);
        wait_idle("hold_idle");

        // Saturation: 300 score pulses stop at 255, and the score survives DEAD/IDLE.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (300) cyc(0, 0, 0, 0, 1);
        chk("sat_score", score, 255);
        repeat (5) cyc(0, 0, 0, 0, 1);
        chk("sat_hold", score, 255);
        cyc(0, 0, 0, 1, 0);
        wait_idle("sat_idle");
        chk("sat_kept_idle", score, 255);

        // Best score over games of 5, 2, 7 and then a mid-game reset.
        cyc(1, 0, 0, 0, 0);
        play_game(5, HS ? 5 : 0, "g5");
        play_game(2, HS ? 5 : 0, "g2");
        play_game(7, HS ? 7 : 0, "g7");
        cyc(0, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        chk("rst_best", best, 0);
        chk("rst_state", state, 0);
        chk("rst_clear", clear, 0);
        chk("rst_score", score, 0);

        // Randomized traffic against the reference model.
        s_cur = 1'b0;
        f_cur = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) s_cur = ~s_cur;
            if ($urandom_range(0, 2) == 0) f_cur = ~f_cur;
            cyc(($urandom_range(0, 199) == 0), s_cur, f_cur,
                ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0));
            check_model(n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter FRAME_DIV, default 20'd833333, clk cycles per game frame (60 Hz at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter DEAD_FRAMES, default 8'd120, frames held in DEAD before returning to IDLE; legal range 1..255.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  start button level, already synchronous to clk.
REQ-006 flap  in  1  flap button level, already synchronous to clk.
REQ-007 collision  in  1  level from collision detector; high means the bird overlaps a pipe or the border.
REQ-008 score_pulse  in  1  one-cycle pulse from the score block when a pipe is passed.
REQ-009 state  out  2  IDLE=0, PLAY=1, DEAD=2; value 3 is unused.
REQ-010 play_en  out  1  high exactly while state==PLAY; drives the counter's enable.
REQ-011 clear  out  1  one-cycle pulse that clears the datapath (pipes, bird, counter).
REQ-012 frame_tick  out  1  one-cycle frame strobe.
REQ-013 flap_o  out  1  one-cycle flap command to the bird datapath.
REQ-014 loser  out  1  high exactly while state==DEAD; selects the LOSER display.
REQ-015 score  out  8  current-game score.
REQ-016 best  out  8  best score since reset.

Function
REQ-017 All outputs shall be registered; each response appears in the cycle after the edge that samples the cause.
REQ-018 Rising edges of start and flap shall be detected against a registered previous value; a held level produces one edge only.
REQ-019 IDLE->PLAY shall occur on a start edge; in the same cycle clear=1, score=0, and the frame divider is zeroed.
REQ-020 PLAY->DEAD shall occur when collision=1 is sampled.
REQ-021 DEAD->IDLE shall occur on the DEAD_FRAMES-th frame_tick after DEAD entry; start edges in DEAD are ignored.
REQ-022 The frame divider shall count 0..FRAME_DIV-1 in PLAY and DEAD, with frame_tick=1 on the cycle after count FRAME_DIV-1; in IDLE the divider is held at 0 and frame_tick=0.
REQ-023 The dead-hold counter shall be zeroed on DEAD entry and incremented on each frame_tick in DEAD.
REQ-024 In PLAY, a flap edge shall produce flap_o=1 for one cycle; flap_o shall be 0 in IDLE and DEAD.
REQ-025 In PLAY, score_pulse shall increment score by 1, saturating at 255; score_pulse in IDLE or DEAD is ignored.
REQ-026 If collision and score_pulse occur in the same cycle, collision wins and score is not incremented.
REQ-027 If collision and a flap edge occur in the same cycle, the state goes to DEAD and flap_o stays 0.
REQ-028 score shall hold its value through DEAD and IDLE until the next clear.

Reset
REQ-029 rst=1 shall force state=IDLE, with play_en, clear, frame_tick, flap_o and loser all 0, score=0, best=0, all counters 0, and the edge-detect registers 0.
REQ-030 rst asserted mid-game shall abort to IDLE on the next edge with no clear pulse; rst has priority over every other input.

Configuration
REQ-031 Macro HIGH_SCORE_EN: when defined, on DEAD entry best <= max(best, score) using the score value after any same-cycle update; best is cleared only by rst.
REQ-032 Without HIGH_SCORE_EN, best shall be constant 0 and no comparator or register shall be inferred for it.

Verification (FRAME_DIV=4, DEAD_FRAMES=3)
REQ-033 rst high for 5 cycles, then start held high for 10 cycles -> exactly one clear pulse, state=1, play_en=1, and frame_tick every 4 cycles.
REQ-034 In PLAY, 3 score_pulses, then score_pulse and collision in the same cycle -> score=3, state=2, loser=1, play_en=0.
REQ-035 In DEAD, a start edge is applied -> ignored; state returns to 0 after the 3rd frame_tick (12 cycles); score stays 3.
REQ-036 In PLAY, a flap edge -> one flap_o pulse; flap held high for 20 cycles -> no further pulses; flap edge in IDLE -> flap_o stays 0.
REQ-037 300 score_pulses in PLAY -> score=255 and holds.
REQ-038 With HIGH_SCORE_EN, play games scoring 5, 2 and 7, then assert rst mid-game -> best=5, 5, 7, then 0, and state=0; without the macro, best=0 throughout.
